// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared widths and FSM encodings for the regfile write arbiter
package regfile_write_arbiter_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HELD  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_MD   = 2'd2,
    GNT_HB   = 2'd3
  } gnt_src_e;

endpackage

// File: rtl/regfile_write_arbiter_wb_hold_buffer.sv
// rtl/regfile_write_arbiter_wb_hold_buffer.sv - one-entry {valid,rd,data} hold buffer with source compares
module wb_hold_buffer
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              capture_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] rd_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [ADDR_W-1:0] rd_o,
  output logic [DATA_W-1:0] data_o,
  input  logic [ADDR_W-1:0] rs_a_i,
  input  logic [ADDR_W-1:0] rs_b_i,
  output logic              hit_a_o,
  output logic              hit_b_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (capture_i) begin
      valid_d = 1'b1;
      rd_d    = rd_i;
      data_d  = data_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  assign rd_o    = rd_q;
  assign data_o  = data_q;
  assign hit_a_o = valid_q && (rs_a_i == rd_q) && (rs_a_i != '0);
  assign hit_b_o = valid_q && (rs_b_i == rd_q) && (rs_b_i != '0);

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the regfile write port between writeback and multdiv results
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned MAX_WAIT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_stall,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [ADDR_W-1:0] md_rd,
  input  logic [DATA_W-1:0] md_data,
  input  logic [ADDR_W-1:0] chk_rs_a,
  input  logic [ADDR_W-1:0] chk_rs_b,
  output logic              chk_hit_a,
  output logic              chk_hit_b,
  output logic              ctrl_writeEnable,
  output logic [ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d, wait_cnt_inc;
  gnt_src_e          gnt_src;
  logic              hb_capture, hb_clear;
  logic [ADDR_W-1:0] hb_rd;
  logic [DATA_W-1:0] hb_data;
  logic              we_q;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              w_req, m_req;

  // r0 requests never touch the port, never stall and never get buffered
  assign w_req = wb_valid && (wb_rd != '0);
  assign m_req = md_valid && (md_rd != '0);

  assign md_ready = (state_q == ST_IDLE);
  assign wb_stall = (state_q == ST_FORCE) && w_req;

  assign wait_cnt_inc = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    gnt_src    = GNT_NONE;
    hb_capture = 1'b0;
    hb_clear   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_req && m_req) begin
          gnt_src    = GNT_WB;
          hb_capture = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_HELD;
        end else if (m_req) begin
          gnt_src = GNT_MD;
        end else if (w_req) begin
          gnt_src = GNT_WB;
        end
      end
      ST_HELD: begin
        if (w_req) begin
          gnt_src = GNT_WB;
          if (wb_rd == hb_rd) begin
            // the younger W write supersedes the held result
            hb_clear = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            wait_cnt_d = wait_cnt_inc;
            if (wait_cnt_inc >= CNT_MAX) begin
              state_d = ST_FORCE;
            end
          end
        end else begin
          gnt_src  = GNT_HB;
          hb_clear = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_FORCE: begin
        gnt_src  = GNT_HB;
        hb_clear = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    case (gnt_src)
      GNT_WB: begin
        wreg_d  = wb_rd;
        wdata_d = wb_data;
      end
      GNT_MD: begin
        wreg_d  = md_rd;
        wdata_d = md_data;
      end
      GNT_HB: begin
        wreg_d  = hb_rd;
        wdata_d = hb_data;
      end
      default: begin
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      we_q       <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      we_q       <= (gnt_src != GNT_NONE);
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
    end
  end

  wb_hold_buffer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_hold (
    .clock     (clock),
    .reset     (reset),
    .capture_i (hb_capture),
    .clear_i   (hb_clear),
    .rd_i      (md_rd),
    .data_i    (md_data),
    .rd_o      (hb_rd),
    .data_o    (hb_data),
    .rs_a_i    (chk_rs_a),
    .rs_b_i    (chk_rs_b),
    .hit_a_o   (chk_hit_a),
    .hit_b_o   (chk_hit_b)
  );

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic [4:0]  chk_rs_a, chk_rs_b;
  logic        chk_hit_a, chk_hit_b;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  int checks = 0;
  int failures = 0;
  int w9_cnt = 0;
  int w12_cnt = 0;

  always #5 clock = ~clock;

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(2)) dut (
    .clock            (clock),
    .reset            (reset),
    .wb_valid         (wb_valid),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .wb_stall         (wb_stall),
    .md_valid         (md_valid),
    .md_ready         (md_ready),
    .md_rd            (md_rd),
    .md_data          (md_data),
    .chk_rs_a         (chk_rs_a),
    .chk_rs_b         (chk_rs_b),
    .chk_hit_a        (chk_hit_a),
    .chk_hit_b        (chk_hit_b),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg)
  );

  always @(negedge clock) begin
    if (ctrl_writeEnable && ctrl_writeReg == 5'd9)  w9_cnt++;
    if (ctrl_writeEnable && ctrl_writeReg == 5'd12) w12_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    md_valid = 1'b0; md_rd = '0; md_data = '0;
  endtask

  task automatic wreq(input logic [4:0] rd, input logic [31:0] d);
    wb_valid = 1'b1; wb_rd = rd; wb_data = d;
  endtask

  task automatic mreq(input logic [4:0] rd, input logic [31:0] d);
    md_valid = 1'b1; md_rd = rd; md_data = d;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, "_we"}, {31'd0, ctrl_writeEnable}, {31'd0, we});
    chk({tag, "_reg"}, {27'd0, ctrl_writeReg}, {27'd0, rd});
    chk({tag, "_data"}, data_writeReg, d);
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    chk_rs_a = '0; chk_rs_b = '0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk_wr("reset", 1'b0, 5'd0, 32'h0);
    chk("reset_md_ready", {31'd0, md_ready}, 32'd1);
    chk("reset_wb_stall", {31'd0, wb_stall}, 32'd0);

    // 1: lone W write
    wreq(5'd5, 32'hAAAA);
    #1 chk("t1_md_ready", {31'd0, md_ready}, 32'd1);
    cyc(); idle_in();
    chk_wr("t1_w5", 1'b1, 5'd5, 32'hAAAA);
    chk("t1_md_ready2", {31'd0, md_ready}, 32'd1);
    cyc();
    chk_wr("t1_hold", 1'b0, 5'd5, 32'hAAAA);

    // 2: collision, buffer drains when W goes quiet
    wreq(5'd3, 32'h33); mreq(5'd7, 32'h1234);
    chk_rs_a = 5'd7; chk_rs_b = 5'd3;
    #1 chk("t2_hit_pre", {31'd0, chk_hit_a}, 32'd0);
    cyc(); idle_in();
    chk_wr("t2_w3", 1'b1, 5'd3, 32'h33);
    chk("t2_md_ready_held", {31'd0, md_ready}, 32'd0);
    chk("t2_hit_a_held", {31'd0, chk_hit_a}, 32'd1);
    chk("t2_hit_b_held", {31'd0, chk_hit_b}, 32'd0);
    cyc();
    chk_wr("t2_m7", 1'b1, 5'd7, 32'h1234);
    chk("t2_hit_a_after", {31'd0, chk_hit_a}, 32'd0);
    chk("t2_md_ready_after", {31'd0, md_ready}, 32'd1);

    // 3: bounded wait forces the buffer out and stalls W once
    wreq(5'd1, 32'h11); mreq(5'd7, 32'h7777);
    cyc(); idle_in();
    chk_wr("t3_w1", 1'b1, 5'd1, 32'h11);
    wreq(5'd4, 32'h44);
    #1 chk("t3_stall_w4", {31'd0, wb_stall}, 32'd0);
    cyc();
    chk_wr("t3_w4", 1'b1, 5'd4, 32'h44);
    wreq(5'd6, 32'h66);
    #1 chk("t3_stall_w6", {31'd0, wb_stall}, 32'd0);
    cyc();
    chk_wr("t3_w6", 1'b1, 5'd6, 32'h66);
    wreq(5'd8, 32'h88);
    #1 chk("t3_stall_force", {31'd0, wb_stall}, 32'd1);
    chk("t3_md_ready_force", {31'd0, md_ready}, 32'd0);
    cyc();
    chk_wr("t3_m7", 1'b1, 5'd7, 32'h7777);
    chk("t3_stall_after", {31'd0, wb_stall}, 32'd0);
    chk("t3_md_ready_after", {31'd0, md_ready}, 32'd1);
    cyc(); idle_in();
    chk_wr("t3_w8", 1'b1, 5'd8, 32'h88);
    cyc();
    chk("t3_quiet_we", {31'd0, ctrl_writeEnable}, 32'd0);

    // 4: younger W to the same rd drops the held result
    wreq(5'd2, 32'h22); mreq(5'd9, 32'h1);
    cyc(); idle_in();
    chk_wr("t4_w2", 1'b1, 5'd2, 32'h22);
    wreq(5'd9, 32'h2);
    chk_rs_a = 5'd9;
    #1 chk("t4_hit_held", {31'd0, chk_hit_a}, 32'd1);
    chk("t4_stall", {31'd0, wb_stall}, 32'd0);
    cyc(); idle_in();
    chk_wr("t4_w9", 1'b1, 5'd9, 32'h2);
    chk("t4_md_ready", {31'd0, md_ready}, 32'd1);
    chk("t4_hit_after", {31'd0, chk_hit_a}, 32'd0);
    cyc();
    chk("t4_no_rewrite", {31'd0, ctrl_writeEnable}, 32'd0);
    cyc();
    chk("t4_w9_once", w9_cnt, 32'd1);

    // 5: r0 requests are no-ops
    wreq(5'd0, 32'hDEAD); mreq(5'd0, 32'hBEEF);
    #1 chk("t5_md_ready", {31'd0, md_ready}, 32'd1);
    chk("t5_stall", {31'd0, wb_stall}, 32'd0);
    cyc();
    chk("t5_no_write", {31'd0, ctrl_writeEnable}, 32'd0);
    wreq(5'd0, 32'hDEAD); mreq(5'd2, 32'h2222);
    #1 chk("t5_md_ready2", {31'd0, md_ready}, 32'd1);
    cyc(); idle_in();
    chk_wr("t5_m2", 1'b1, 5'd2, 32'h2222);
    chk("t5_md_ready3", {31'd0, md_ready}, 32'd1);

    // 6: reset while HELD discards the buffered result
    wreq(5'd1, 32'h10); mreq(5'd12, 32'hC);
    chk_rs_a = 5'd12;
    cyc(); idle_in();
    chk("t6_hit_held", {31'd0, chk_hit_a}, 32'd1);
    chk("t6_md_ready_held", {31'd0, md_ready}, 32'd0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk_wr("t6_reset", 1'b0, 5'd0, 32'h0);
    chk("t6_md_ready", {31'd0, md_ready}, 32'd1);
    chk("t6_hit_cleared", {31'd0, chk_hit_a}, 32'd0);
    cyc(); cyc();
    chk("t6_no_write", {31'd0, ctrl_writeEnable}, 32'd0);
    chk("t6_r12_never", w12_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
